// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
package pwm_pkg;

    // Counting mode of the shared period counter.
    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTRE = 1'b1
    } mode_e;

    // Direction of the centre-aligned counter; edge mode always counts up.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Lowest bit index of channel i inside a packed CH*w duty bus.
    function automatic int duty_slice(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: pending/active duty pair, compare against the shared
// counter, optional inversion and the output register.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int   W   = 5,
    parameter logic INV = 1'b0
) (
    input  logic         clk_out,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         take_in,
    input  logic         take_p,
    input  logic [W-1:0] duty_in,
    input  logic [W-1:0] cnt,
    output logic         pwm_out
);

    logic [W-1:0] duty_p;
    logic [W-1:0] duty_a;

    // Shadow duty capture, transfer to active, and registered compare output.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            duty_p  <= '0;
            duty_a  <= '0;
            pwm_out <= INV;
        end else begin
            if (load)
                duty_p <= duty_in;
            // A load while idle bypasses the shadow and goes straight to active.
            if (take_in)
                duty_a <= duty_in;
            else if (take_p)
                duty_a <= duty_p;
            pwm_out <= en ? ((duty_a > cnt) ^ INV) : INV;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter (edge or centre aligned),
// double-buffered period/duty/mode applied on period boundaries, and
// CH comparator channels.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int             CH         = 2,
    parameter int             W          = 5,
    parameter logic [W-1:0]   PERIOD_RST = {W{1'b1}},
    parameter logic [CH-1:0]  INV        = '0
) (
    input  logic            clk_out,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic            mode_in,
    input  logic [W-1:0]    period_in,
    input  logic [CH*W-1:0] duty_in,
    output logic [CH-1:0]   pwm_out,
    output logic            sync,
    output logic            upd
);

    logic [W-1:0] cnt;
    dir_e         dir;
    logic [W-1:0] per_a;
    logic [W-1:0] per_p;
    mode_e        mode_a;
    mode_e        mode_p;
    logic         pend;

    logic         bnd;
    logic         take_in;
    logic         take_p;

    // Period boundary: last cycle of the current period. In centre mode a
    // period of 1 peaks and ends on the same count, and 0 ends every cycle.
    always_comb begin
        bnd = 1'b0;
        if (mode_a == MODE_EDGE)
            bnd = (cnt == per_a);
        else
            bnd = (per_a == '0) ||
                  ((cnt == W'(1)) && ((dir == DIR_DOWN) || (per_a == W'(1))));
    end

    // Idle load goes straight to active; otherwise pending moves over at a
    // boundary, or at once when idle.
    assign take_in = !en && load;
    assign take_p  = en ? (bnd && pend) : (pend && !load);

    // Shared period counter with up/down direction for centre mode.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (!en || bnd) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (mode_a == MODE_EDGE) begin
            cnt <= cnt + W'(1);
        end else if (dir == DIR_UP) begin
            if (cnt == per_a) begin
                dir <= DIR_DOWN;
                cnt <= cnt - W'(1);
            end else begin
                cnt <= cnt + W'(1);
            end
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    // Period/mode shadow registers and the pending flag.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            per_a  <= PERIOD_RST;
            per_p  <= PERIOD_RST;
            mode_a <= MODE_EDGE;
            mode_p <= MODE_EDGE;
            pend   <= 1'b0;
        end else begin
            if (load) begin
                per_p  <= period_in;
                mode_p <= mode_e'(mode_in);
            end
            if (take_in) begin
                per_a  <= period_in;
                mode_a <= mode_e'(mode_in);
            end else if (take_p) begin
                per_a  <= per_p;
                mode_a <= mode_p;
            end
            // A load coinciding with a transfer keeps pend set for the new set.
            if (take_in)
                pend <= 1'b0;
            else if (load)
                pend <= 1'b1;
            else if (take_p)
                pend <= 1'b0;
        end
    end

    // Registered period-start and update strobes.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            sync <= 1'b0;
            upd  <= 1'b0;
        end else begin
            sync <= en && bnd;
            upd  <= take_in || take_p;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_chan #(
            .W   (W),
            .INV (INV[i])
        ) u_chan (
            .clk_out (clk_out),
            .reset   (reset),
            .en      (en),
            .load    (load),
            .take_in (take_in),
            .take_p  (take_p),
            .duty_in (duty_in[duty_slice(i, W) +: W]),
            .cnt     (cnt),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a period-position model predicts every output each
// cycle, and directed windows pin duty/sync/upd counts to literal values.
module tb_pwm_multi;

    localparam int          CH    = 2;
    localparam int          W     = 5;
    localparam logic [1:0]  INV_T = 2'b01;

    logic              clk_out = 1'b0;
    logic              reset;
    logic              en;
    logic              load;
    logic              mode_in;
    logic [W-1:0]      period_in;
    logic [CH*W-1:0]   duty_in;
    logic [CH-1:0]     pwm_out;
    logic              sync;
    logic              upd;

    int checks = 0;
    int errors = 0;

    pwm_multi #(
        .CH  (CH),
        .W   (W),
        .INV (INV_T)
    ) dut (
        .clk_out   (clk_out),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .mode_in   (mode_in),
        .period_in (period_in),
        .duty_in   (duty_in),
        .pwm_out   (pwm_out),
        .sync      (sync),
        .upd       (upd)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: position k inside the current period ----------
    int              m_per_a, m_per_p, m_k;
    bit              m_mode_a, m_mode_p, m_pend;
    int              m_duty_a [CH];
    int              m_duty_p [CH];
    logic [CH-1:0]   e_pwm;
    logic            e_sync, e_upd;

    function automatic int plen(input int per, input bit mode);
        if (!mode) return per + 1;
        if (per == 0) return 1;
        return 2 * per;
    endfunction

    function automatic int cnt_at(input int k, input int per, input bit mode);
        if (!mode) return k;
        return (k <= per) ? k : 2 * per - k;
    endfunction

    function automatic bit m_bnd();
        return m_k == plen(m_per_a, m_mode_a) - 1;
    endfunction

    function automatic logic [CH-1:0] m_level();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++)
            v[i] = (m_duty_a[i] > cnt_at(m_k, m_per_a, m_mode_a));
        return v;
    endfunction

    always @(posedge clk_out or posedge reset) begin
        if (reset) begin
            m_per_a <= 31; m_per_p <= 31; m_mode_a <= 0; m_mode_p <= 0;
            m_pend <= 0; m_k <= 0;
            for (int i = 0; i < CH; i++) begin
                m_duty_a[i] <= 0; m_duty_p[i] <= 0;
            end
            e_pwm <= INV_T; e_sync <= 0; e_upd <= 0;
        end else begin
            e_pwm  <= en ? (m_level() ^ INV_T) : INV_T;
            e_sync <= en && m_bnd();
            if (!en) begin
                m_k <= 0;
                if (load) begin
                    m_per_a <= int'(period_in); m_per_p <= int'(period_in);
                    m_mode_a <= mode_in; m_mode_p <= mode_in;
                    for (int i = 0; i < CH; i++) begin
                        m_duty_a[i] <= int'(duty_in[i*W +: W]);
                        m_duty_p[i] <= int'(duty_in[i*W +: W]);
                    end
                    m_pend <= 0; e_upd <= 1;
                end else if (m_pend) begin
                    m_per_a <= m_per_p; m_mode_a <= m_mode_p;
                    for (int i = 0; i < CH; i++) m_duty_a[i] <= m_duty_p[i];
                    m_pend <= 0; e_upd <= 1;
                end else begin
                    e_upd <= 0;
                end
            end else begin
                m_k   <= m_bnd() ? 0 : m_k + 1;
                e_upd <= m_bnd() && m_pend;
                if (m_bnd() && m_pend) begin
                    m_per_a <= m_per_p; m_mode_a <= m_mode_p;
                    for (int i = 0; i < CH; i++) m_duty_a[i] <= m_duty_p[i];
                end
                if (load) begin
                    m_per_p <= int'(period_in); m_mode_p <= mode_in;
                    for (int i = 0; i < CH; i++) m_duty_p[i] <= int'(duty_in[i*W +: W]);
                    m_pend <= 1;
                end else if (m_bnd()) begin
                    m_pend <= 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_out) begin
        if (reset === 1'b0) begin
            chk("cyc_pwm",  pwm_out, e_pwm);
            chk("cyc_sync", sync,    e_sync);
            chk("cyc_upd",  upd,     e_upd);
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_out);
    endtask

    task automatic do_load(input bit m, input int per, input int d0, input int d1);
        mode_in   = m;
        period_in = W'(per);
        duty_in   = {W'(d1), W'(d0)};
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic wait_upd(input int budget);
        int n = 0;
        while (!upd && n < budget) begin tick(); n++; end
        chk("upd_seen", upd, 1);
    endtask

    task automatic wait_sync(input int budget);
        int n = 0;
        while (!sync && n < budget) begin tick(); n++; end
        chk("sync_seen", sync, 1);
    endtask

    // Logical (pre-inversion) high counts plus strobe counts over n cycles.
    task automatic measure(input int n, output int h0, output int h1, output int s, output int u);
        h0 = 0; h1 = 0; s = 0; u = 0;
        repeat (n) begin
            tick();
            h0 += int'(pwm_out[0] ^ INV_T[0]);
            h1 += int'(pwm_out[1] ^ INV_T[1]);
            s  += int'(sync);
            u  += int'(upd);
        end
    endtask

    initial begin
        int h0, h1, s, u;
        reset = 0; en = 0; load = 0; mode_in = 0; period_in = '0; duty_in = '0;
        #1 reset = 1;
        #2;
        chk("rst_pwm", pwm_out, 2'b01);
        chk("rst_sync", sync, 0);
        chk("rst_upd", upd, 0);
        tick(2);
        reset = 0;
        tick(2);

        // Edge duty sweep: period 9, duty {3,7}.
        en = 1;
        do_load(0, 9, 3, 7);
        wait_upd(40);
        tick();
        measure(20, h0, h1, s, u);
        chk("edge_ch0_high", h0, 6);
        chk("edge_ch1_high", h1, 14);
        chk("edge_sync", s, 2);

        // Extremes: duty 0 and duty 10, then 31.
        do_load(0, 9, 0, 10);
        wait_upd(15);
        tick();
        measure(20, h0, h1, s, u);
        chk("ext_d0_high", h0, 0);
        chk("ext_d10_high", h1, 20);
        chk("ext_inv_pins", pwm_out, 2'b11);
        do_load(0, 9, 0, 31);
        wait_upd(15);
        tick();
        measure(20, h0, h1, s, u);
        chk("ext_d31_high", h1, 20);

        // Shadowing: 3 -> 6 mid-period, then a load right on the boundary.
        do_load(0, 9, 3, 3);
        wait_upd(15);
        wait_sync(15);
        tick(4);
        do_load(0, 9, 6, 6);
        tick(4);
        do_load(0, 9, 2, 2);
        chk("shadow_upd_at_bnd", upd, 1);
        measure(10, h0, h1, s, u);
        chk("shadow_new_duty", h0, 6);
        chk("shadow_second_upd", u, 1);
        chk("shadow_second_upd_last", upd, 1);

        // Centre mode: period 8, duty 4.
        do_load(1, 8, 4, 4);
        wait_upd(15);
        tick();
        measure(32, h0, h1, s, u);
        chk("ctr_ch0_high", h0, 14);
        chk("ctr_ch1_high", h1, 14);
        chk("ctr_sync", s, 2);

        // Disable mid-period with a pending load.
        do_load(1, 8, 5, 5);
        en = 0;
        tick();
        chk("dis_pwm_inv", pwm_out, 2'b01);
        chk("dis_upd", upd, 1);
        do_load(0, 9, 3, 7);
        chk("dis_load_upd", upd, 1);
        en = 1;
        measure(9, h0, h1, s, u);
        chk("en_no_early_sync", s, 0);
        tick();
        chk("en_first_sync", sync, 1);

        // Asynchronous reset mid-period, checked before any clock edge.
        tick(3);
        #2 reset = 1;
        #1;
        chk("async_pwm", pwm_out, 2'b01);
        chk("async_sync", sync, 0);
        chk("async_upd", upd, 0);
        tick(2);
        reset = 0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
